// File: rtl/triplet_loader.sv
// -----------------------------------------------------------------------------
// triplet_loader
//
// Takes a serial byte stream over a valid/ready handshake and packs three
// consecutive bytes into the operand registers a, b and c. Once all three are
// in, it raises trip_valid and holds the operands stable until the downstream
// min/max/diff stage accepts them with trip_ready.
//
// Ports
//   clk         single clock; all state changes on the rising edge
//   rst_n       asynchronous, active-low reset
//   clear       synchronous abort; drops a partial or held triplet
//   in_data     incoming byte (WIDTH bits)
//   in_valid    in_data is valid this cycle
//   in_ready    loader can accept a byte this cycle (decoded from state)
//   a, b, c     first, second and third byte of the current triplet
//   trip_valid  a, b and c form a complete triplet (high in HOLD)
//   trip_ready  downstream consumes the triplet this cycle
//   fill        bytes collected in the current triplet (0..3)
//   trip_cnt    triplets delivered since reset, modulo 256
// -----------------------------------------------------------------------------
module triplet_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic             trip_valid,
    input  logic             trip_ready,
    output logic [1:0]       fill,
    output logic [7:0]       trip_cnt
);

    // The encoding equals the number of bytes collected, so fill is the
    // state register itself.
    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [7:0]       r_trip_cnt;
    logic             w_accept;

    // Outputs depend on registered state only, never on in_valid/trip_ready.
    assign in_ready   = (r_state != HOLD);
    assign trip_valid = (r_state == HOLD);
    assign fill       = r_state;
    assign w_accept   = in_valid & in_ready;

    assign a        = r_a;
    assign b        = r_b;
    assign c        = r_c;
    assign trip_cnt = r_trip_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FILL0;
            // NOTE: operands are reset on purpose; afterwards they are only
            // overwritten by an accept, never cleared, so clear leaves them.
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_trip_cnt <= '0;
        end else if (clear) begin
            // Abort wins over a simultaneous accept or consume.
            r_state <= FILL0;
        end else begin
            case (r_state)
                FILL0: if (w_accept) begin
                    r_a     <= in_data;
                    r_state <= FILL1;
                end
                FILL1: if (w_accept) begin
                    r_b     <= in_data;
                    r_state <= FILL2;
                end
                FILL2: if (w_accept) begin
                    r_c     <= in_data;
                    r_state <= HOLD;
                end
                HOLD: if (trip_ready) begin
                    r_trip_cnt <= r_trip_cnt + 8'd1;
                    r_state    <= FILL0;
                end
                default: r_state <= FILL0;
            endcase
        end
    end

endmodule

// File: doc/triplet_loader.md
# triplet_loader

Upstream feeder for the three-operand min/max/difference stage. Accepts a serial byte stream over a valid/ready handshake, collects three consecutive bytes into operand registers a, b and c, and holds them stable with a valid flag until the downstream stage acknowledges. The combinational min/max/diff stage connects directly to a/b/c. Its registered results are sampled on the same cycle that trip_valid and trip_ready are both high.

## Interface
- WIDTH, 8: operand/byte width; a, b, c and in_data are all WIDTH bits.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort; discards a partially collected triplet.
- in_data  input  WIDTH  incoming byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader can accept a byte this cycle.
- a  output  WIDTH  first byte of the current triplet.
- b  output  WIDTH  second byte of the current triplet.
- c  output  WIDTH  third byte of the current triplet.
- trip_valid  output  1  a, b and c form a complete triplet.
- trip_ready  input  1  downstream consumes the triplet this cycle.
- fill  output  2  bytes collected in the current triplet (0..3).
- trip_cnt  output  8  triplets delivered since reset, modulo 256.

## Operation
- The FSM has four states:
  - FILL0: waiting for byte a; fill=0.
  - FILL1: waiting for byte b; fill=1.
  - FILL2: waiting for byte c; fill=2.
  - HOLD: triplet complete; fill=3.
- in_ready = 1 in FILL0/FILL1/FILL2 and 0 in HOLD. in_ready is decoded from state only and does not depend on in_valid or trip_ready.
- A byte is accepted when in_valid & in_ready:
  - FILL0: a <= in_data, go to FILL1.
  - FILL1: b <= in_data, go to FILL2.
  - FILL2: c <= in_data, go to HOLD.
- With no accept, the FSM stays in its current state.
- trip_valid = 1 exactly when in HOLD.
- In HOLD, trip_ready=1 returns the FSM to FILL0 and increments trip_cnt, which wraps 255 -> 0. With trip_ready=0 the FSM stays in HOLD; a, b and c are held.
- trip_ready is ignored outside HOLD. It has no effect on state or trip_cnt.
- There is no bypass: a byte offered in the same cycle that HOLD is released is not accepted, because in_ready=0.
- a, b and c are never cleared after reset. They keep their last values until overwritten by a new accept.
- clear=1 forces the FSM to FILL0 next cycle from any state, including HOLD, so a held triplet is dropped.
  - clear does not change a, b, c or trip_cnt.
  - clear has priority over a simultaneous accept or trip_ready. The byte is not stored, and trip_cnt is not incremented.
- Reset (rst_n=0, asynchronous assert) sets:
  - state = FILL0;
  - a = b = c = 0;
  - trip_cnt = 0.
- Resulting output values during reset: trip_valid=0, in_ready=1, fill=0.
- Reset asserted mid-triplet discards all collected bytes immediately.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from in_valid, in_data or trip_ready to any output.
- Latency: trip_valid rises in the cycle after the third byte is accepted.
- Minimum period is 4 cycles per triplet: 3 accept cycles plus 1 HOLD cycle with trip_ready=1.
- a, b and c are stable for every cycle in which trip_valid=1.
- trip_cnt updates in the cycle after the handshake.
- rst_n deassertion is synchronised externally. The first accept can happen on the first rising edge with rst_n=1.

## Test plan
- **Reset values:** hold rst_n=0 and then release it. Required: a=b=c=0, trip_valid=0, in_ready=1, fill=0, trip_cnt=0. Then assert rst_n=0 asynchronously mid-cycle while in FILL2. Required: outputs return to these reset values without waiting for a clock edge.
- **Back-to-back triplet with immediate consume:**
  - Stimulus: stream 0x12, 0xF0, 0x07 with in_valid=1 continuously, and trip_ready=1.
  - Required: a=0x12, b=0xF0, c=0x07 and trip_valid=1 on cycle 4.
  - Required: FSM back in FILL0 on cycle 5, with trip_cnt=1 and in_ready low only on cycle 4.
- **Input bubbles and downstream backpressure:**
  - Stimulus: in_valid toggles 1,0,1,0,1 with bytes 0x01, 0x02, 0x03; trip_ready held at 0 for 5 cycles after trip_valid rises.
  - Required: fill counts 0,1,1,2,2,3.
  - Required: a/b/c hold 0x01/0x02/0x03 and in_ready=0 throughout the stall, and trip_cnt is unchanged until trip_ready=1.
- **Clear mid-triplet and during HOLD:**
  - Stimulus A: after 0xAA and 0xBB are accepted, pulse clear together with in_valid=1, in_data=0xCC.
  - Required A: FILL0, fill=0, c not written, a=0xAA retained.
  - Stimulus B: pulse clear in HOLD together with trip_ready=1.
  - Required B: trip_valid drops and trip_cnt is not incremented.
- **trip_cnt wrap-around:** deliver 256 triplets. Required: trip_cnt reads 255 after the 255th triplet and 0 after the 256th.
- **Stray trip_ready outside HOLD:** assert trip_ready=1 in FILL1. Required: no state change and no trip_cnt change.
